// File: rtl/vga_pkg.sv
// Shared types and word layout for the VGA frame buffer.
// Each stored word is {sof, rgb}.
package vga_pkg;

   typedef enum logic [1:0] {
      ALIGN,
      WAIT_VS,
      STREAM
   } fifo_state_t;

   localparam int SOF_BIT = 24;
   localparam int RGB_W   = 24;
   localparam int WORD_W  = RGB_W + 1;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with an asynchronous-read array.
// It also provides a registered level count and full/empty flags.
module sync_fifo_fwft #(
   parameter int DEPTH = 1024,
   parameter int LW    = $clog2(DEPTH) + 1,
   parameter int W     = 25
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          Push_i,
   input  logic [W-1:0]  Wr_Data_i,
   input  logic          Pop_i,
   output logic [W-1:0]  Rd_Data_o,
   output logic [LW-1:0] Level_o,
   output logic          Full_o,
   output logic          Empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [LW-1:0] level_q, level_d;
   logic          doPush, doPop;

   assign Full_o    = (level_q == LW'(DEPTH));
   assign Empty_o   = (level_q == '0);
   assign doPush    = Push_i && !Full_o;
   assign doPop     = Pop_i && !Empty_o;
   assign Rd_Data_o = mem_q[rdPtr_q];
   assign Level_o   = level_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      level_d = level_q;
      if (doPush) wrPtr_d = wrPtr_q + AW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
      if (doPush && !doPop)      level_d = level_q + LW'(1);
      else if (doPop && !doPush) level_d = level_q - LW'(1);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (doPush) mem_q[wrPtr_q] <= Wr_Data_i;
   end

endmodule

// File: rtl/vga_frame_fifo.sv
// Pixel buffer ahead of the VGA timing controller: keeps producer frames
// aligned to vertical sync, recovers from short/long frames, flags underflow.
module vga_frame_fifo
   import vga_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [RGB_W-1:0] Wr_Data,
   input  logic             Wr_Sof,
   input  logic             Wr_Valid,
   output logic             Wr_Ready,
   input  logic             Data_Req,
   output logic [RGB_W-1:0] DATA,
   input  logic             Vga_Vs,
   output logic [LW-1:0]    Level,
   output logic             Underflow,
   output logic             Resync
);

   fifo_state_t       state_q, state_d;
   logic              first_q, first_d;
   logic              underflow_q, underflow_d;
   logic              resync_q, resync_d;
   logic              vsD_q;
   logic              vsRise;
   logic              pop;
   logic              fifoFull, fifoEmpty;
   logic [WORD_W-1:0] headWord;
   logic              headSof;
   logic              shortStall;

   sync_fifo_fwft #(
      .DEPTH (DEPTH),
      .LW    (LW),
      .W     (WORD_W)
   ) uFifo (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Push_i    (Wr_Valid),
      .Wr_Data_i ({Wr_Sof, Wr_Data}),
      .Pop_i     (pop),
      .Rd_Data_o (headWord),
      .Level_o   (Level),
      .Full_o    (fifoFull),
      .Empty_o   (fifoEmpty)
   );

   assign headSof    = headWord[SOF_BIT];
   assign vsRise     = Vga_Vs && !vsD_q;
   assign shortStall = headSof && !first_q;
   assign Wr_Ready   = !fifoFull;
   assign Underflow  = underflow_q;
   assign Resync     = resync_q;
   assign DATA       = (state_q == STREAM && !fifoEmpty && !shortStall)
                       ? headWord[RGB_W-1:0] : '0;

   // A vsync edge in STREAM takes priority over that cycle's pixel request.
   always_comb begin
      state_d     = state_q;
      first_d     = first_q;
      underflow_d = underflow_q;
      resync_d    = 1'b0;
      pop         = 1'b0;
      case (state_q)
         ALIGN: begin
            if (!fifoEmpty) begin
               if (headSof) state_d = WAIT_VS;
               else         pop     = 1'b1;
            end
         end
         WAIT_VS: begin
            if (vsRise) begin
               state_d = STREAM;
               first_d = 1'b1;
            end
         end
         STREAM: begin
            if (vsRise) begin
               if (!fifoEmpty && headSof) begin
                  first_d = 1'b1;
               end else begin
                  resync_d = 1'b1;
                  state_d  = ALIGN;
               end
            end else if (Data_Req) begin
               if (fifoEmpty) begin
                  underflow_d = 1'b1;
               end else if (shortStall) begin
                  resync_d = 1'b1;
                  state_d  = WAIT_VS;
               end else begin
                  pop     = 1'b1;
                  first_d = 1'b0;
               end
            end
         end
         default: state_d = ALIGN;
      endcase
   end

   // vsD_q resets high so leaving reset with Vga_Vs high is not an edge.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ALIGN;
         first_q     <= 1'b0;
         underflow_q <= 1'b0;
         resync_q    <= 1'b0;
         vsD_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         first_q     <= first_d;
         underflow_q <= underflow_d;
         resync_q    <= resync_d;
         vsD_q       <= Vga_Vs;
      end
   end

endmodule

// File: tb/tb_vga_frame_fifo.sv
// Directed self-checking bench for vga_frame_fifo (DEPTH = 8).
// Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
module tb_vga_frame_fifo;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [23:0] Wr_Data = '0;
   logic        Wr_Sof = 1'b0;
   logic        Wr_Valid = 1'b0;
   logic        Wr_Ready;
   logic        Data_Req = 1'b0;
   logic [23:0] DATA;
   logic        Vga_Vs = 1'b1;
   logic [3:0]  Level;
   logic        Underflow;
   logic        Resync;

   int passCount  = 0;
   int failCount  = 0;
   int checkCount = 0;

   logic [23:0] pix [0:8] = '{24'h110000, 24'h220011, 24'h330022, 24'h440033,
                              24'h550044, 24'h660055, 24'h770066, 24'h880077,
                              24'h990088};

   vga_frame_fifo #(.DEPTH(8), .LW(4)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Wr_Data   (Wr_Data),
      .Wr_Sof    (Wr_Sof),
      .Wr_Valid  (Wr_Valid),
      .Wr_Ready  (Wr_Ready),
      .Data_Req  (Data_Req),
      .DATA      (DATA),
      .Vga_Vs    (Vga_Vs),
      .Level     (Level),
      .Underflow (Underflow),
      .Resync    (Resync)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [23:0] data,
                                input logic sof, input logic req);
      Wr_Valid = valid;
      Wr_Data  = data;
      Wr_Sof   = sof;
      Data_Req = req;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checkCount = checkCount + 1;
      assert (obs === exp) passCount = passCount + 1;
      else begin
         failCount = failCount + 1;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic vsPulse();
      Vga_Vs = 1'b0;
      tick();
      Vga_Vs = 1'b1;
      tick();
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      Vga_Vs  = 1'b1;
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
   endtask

   initial begin
      // Reset values
      tick();
      tick();
      checkOutput("rst_level", 32'(Level), 32'd0);
      checkOutput("rst_ready", 32'(Wr_Ready), 32'd1);
      checkOutput("rst_data", 32'(DATA), 32'd0);
      checkOutput("rst_underflow", 32'(Underflow), 32'd0);
      checkOutput("rst_resync", 32'(Resync), 32'd0);
      Reset_n = 1'b1;
      tick();

      // Basic frame: 4 pixels streamed after vsync
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, pix[i], (i == 0), 1'b0);
         tick();
      end
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("basic_level4", 32'(Level), 32'd4);
      checkOutput("basic_hold_data", 32'(DATA), 32'd0);
      vsPulse();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
         checkOutput($sformatf("basic_data%0d", i), 32'(DATA), 32'(pix[i]));
         checkOutput($sformatf("basic_level%0d", i), 32'(Level), 32'(4 - i));
         tick();
      end
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("basic_level0", 32'(Level), 32'd0);
      checkOutput("basic_empty_data", 32'(DATA), 32'd0);
      checkOutput("basic_underflow", 32'(Underflow), 32'd0);

      // Full: 9 back-to-back writes into an 8-deep FIFO
      doReset();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, pix[i], (i == 0), 1'b0);
         tick();
      end
      checkOutput("full_ready", 32'(Wr_Ready), 32'd0);
      checkOutput("full_level", 32'(Level), 32'd8);
      applyStimulus(1'b1, pix[8], 1'b0, 1'b0);
      tick();
      checkOutput("full_held_level", 32'(Level), 32'd8);
      vsPulse();
      applyStimulus(1'b1, pix[8], 1'b0, 1'b1);
      checkOutput("full_head", 32'(DATA), 32'(pix[0]));
      tick();
      applyStimulus(1'b1, pix[8], 1'b0, 1'b0);
      checkOutput("full_pop_ready", 32'(Wr_Ready), 32'd1);
      checkOutput("full_pop_level", 32'(Level), 32'd7);
      tick();
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("full_ninth_level", 32'(Level), 32'd8);
      checkOutput("full_ninth_ready", 32'(Wr_Ready), 32'd0);

      // Alignment: 3 non-SOF words discarded, SOF word held until vsync
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, pix[i], (i == 3), 1'b0);
         tick();
      end
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("align_level", 32'(Level), 32'd1);
      checkOutput("align_hold_data", 32'(DATA), 32'd0);
      tick();
      checkOutput("align_still_level", 32'(Level), 32'd1);
      vsPulse();
      checkOutput("align_stream_data", 32'(DATA), 32'(pix[3]));

      // Short frame: A0 A1 then B0(SOF)
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, pix[i], (i != 1), 1'b0);
         tick();
      end
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      tick();
      vsPulse();
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
      checkOutput("short_a0", 32'(DATA), 32'(pix[0]));
      tick();
      checkOutput("short_a1", 32'(DATA), 32'(pix[1]));
      tick();
      checkOutput("short_stall_data", 32'(DATA), 32'd0);
      tick();
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("short_resync_hi", 32'(Resync), 32'd1);
      checkOutput("short_level", 32'(Level), 32'd1);
      tick();
      checkOutput("short_resync_lo", 32'(Resync), 32'd0);
      vsPulse();
      checkOutput("short_b0", 32'(DATA), 32'(pix[2]));
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("short_b0_popped", 32'(Level), 32'd0);

      // Long frame: F0..F5 then G0(SOF); vsync after one pop
      doReset();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, pix[i], (i == 0 || i == 6), 1'b0);
         tick();
      end
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      vsPulse();
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
      checkOutput("long_f0", 32'(DATA), 32'(pix[0]));
      tick();
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("long_level6", 32'(Level), 32'd6);
      vsPulse();
      checkOutput("long_resync_hi", 32'(Resync), 32'd1);
      tick();
      checkOutput("long_resync_lo", 32'(Resync), 32'd0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("long_discard_level", 32'(Level), 32'd1);
      checkOutput("long_hold_data", 32'(DATA), 32'd0);
      vsPulse();
      checkOutput("long_g0", 32'(DATA), 32'(pix[6]));
      checkOutput("long_no_resync", 32'(Resync), 32'd0);

      // Underflow: empty request with a simultaneous write, then mid-frame reset
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b1, pix[7], 1'b0, 1'b1);
      checkOutput("under_data", 32'(DATA), 32'd0);
      tick();
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
      checkOutput("under_set", 32'(Underflow), 32'd1);
      checkOutput("under_write_level", 32'(Level), 32'd1);
      checkOutput("under_write_data", 32'(DATA), 32'(pix[7]));
      tick();
      tick();
      checkOutput("under_sticky", 32'(Underflow), 32'd1);
      Reset_n = 1'b0;
      #1;
      checkOutput("reset_underflow", 32'(Underflow), 32'd0);
      checkOutput("reset_level", 32'(Level), 32'd0);
      checkOutput("reset_data", 32'(DATA), 32'd0);
      checkOutput("reset_ready", 32'(Wr_Ready), 32'd1);
      tick();
      Reset_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
